// File: rtl/digit_renderer.sv
// digit_renderer: scans a row of NUM_DIGITS ROM glyphs at a fixed origin, 2^SCALE_LOG2 pixel
// replication, 2-stage pixel pipeline. Define LEAD_ZERO_BLANK_EN to blank leading zero digits.
module digit_renderer #(
  parameter int unsigned BIT_WIDTH  = 20,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned GAP        = 4,
  parameter int unsigned ORIGIN_X   = 200,
  parameter int unsigned ORIGIN_Y   = 200,
  parameter logic [11:0] FG         = 12'hFFF,
  parameter logic [11:0] BG         = 12'h000
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                pix_en_i,
  input  logic [9:0]                          pix_x_i,
  input  logic [9:0]                          pix_y_i,
  input  logic                                video_on_i,
  input  logic                                hsync_i,
  input  logic                                vsync_i,
  input  logic [4*NUM_DIGITS-1:0]             digits_i,
  input  logic                                digits_valid_i,
  output logic [3:0]                          sel_o,
  input  logic [BIT_WIDTH-1:0][BIT_WIDTH-1:0] bitmap_i,
  output logic [11:0]                         rgb_o,
  output logic                                hsync_o,
  output logic                                vsync_o
);

  localparam int unsigned CW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SW = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [9:0]    OX       = 10'(ORIGIN_X);
  localparam logic [9:0]    OY       = 10'(ORIGIN_Y);
  localparam logic [9:0]    Y_END    = 10'(ORIGIN_Y + (BIT_WIDTH << SCALE_LOG2));
  localparam logic [CW-1:0] COL_LAST = CW'(BIT_WIDTH - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'((1 << SCALE_LOG2) - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  logic [4*NUM_DIGITS-1:0] pending_q, display_q;
  logic                    h_active_q, h_active_d;
  logic [DW-1:0]           dig_q, dig_d;
  logic [CW-1:0]           col_q, col_d;
  logic [SW-1:0]           sub_q, sub_d;
  logic                    gap_q, gap_d;
  logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
  logic [CW-1:0]           row_q, row_d;
  logic [3:0]              sel_q, sel_d;
  logic                    on_box_q, on_box_d;
  logic [11:0]             rgb_q, rgb_d;
  logic                    hs1_q, vs1_q, hs2_q, vs2_q;
  logic                    v_in_s, frame_start_s;
  logic [3:0]              nib_s [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank_s;

  assign frame_start_s = (pix_x_i == 10'd0) && (pix_y_i == 10'd0);
  assign v_in_s        = (pix_y_i >= OY) && (pix_y_i < Y_END);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign nib_s[g] = display_q[4*(NUM_DIGITS-1-g) +: 4];
  end

`ifdef LEAD_ZERO_BLANK_EN
  // A digit is blanked while it is zero and no nonzero digit lies to its left.
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    blank_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (nib_s[i] != 4'h0) begin
        seen_nz = 1'b1;
      end else begin
        seen_nz = seen_nz;
      end
      blank_s[i] = ~seen_nz & (i != NUM_DIGITS - 1);
    end
  end
`else
  assign blank_s = '0;
`endif

  // Horizontal scan next state: sub-pixel, column, inter-digit gap and digit index.
  always_comb begin
    h_active_d = h_active_q;
    dig_d      = dig_q;
    col_d      = col_q;
    sub_d      = sub_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    if (pix_x_i == OX) begin
      h_active_d = 1'b1;
      dig_d      = '0;
      col_d      = '0;
      sub_d      = '0;
      gap_d      = 1'b0;
      gap_cnt_d  = '0;
    end else if (!h_active_q) begin
      h_active_d = 1'b0;
    end else if (gap_q) begin
      if (gap_cnt_q == GAP_LAST) begin
        gap_d     = 1'b0;
        gap_cnt_d = '0;
        dig_d     = dig_q + 1'b1;
        col_d     = '0;
        sub_d     = '0;
      end else begin
        gap_cnt_d = gap_cnt_q + 1'b1;
      end
    end else if (sub_q != SUB_LAST) begin
      sub_d = sub_q + 1'b1;
    end else begin
      sub_d = '0;
      if (col_q != COL_LAST) begin
        col_d = col_q + 1'b1;
      end else if (dig_q != DIG_LAST) begin
        col_d = '0;
        if (GAP == 0) begin
          dig_d = dig_q + 1'b1;
        end else begin
          gap_d     = 1'b1;
          gap_cnt_d = '0;
        end
      end else begin
        col_d      = '0;
        h_active_d = 1'b0;
      end
    end
  end

  // Stage-1 glyph select, row and box qualification; stage-2 colour.
  always_comb begin
    sel_d    = nib_s[dig_d];
    on_box_d = v_in_s && h_active_d && !gap_d && video_on_i && !blank_s[dig_d];
    if (v_in_s) begin
      row_d = CW'((pix_y_i - OY) >> SCALE_LOG2);
    end else begin
      row_d = '0;
    end
    if (on_box_q && bitmap_i[row_q][col_q]) begin
      rgb_d = FG;
    end else begin
      rgb_d = BG;
    end
  end

  // Pending register loads on any clock, independent of the pixel enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '1;
    end else if (digits_valid_i) begin
      pending_q <= digits_i;
    end
  end

  // Pixel-rate pipeline; display takes the pre-write pending value at frame start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      display_q  <= '1;
      h_active_q <= 1'b0;
      dig_q      <= '0;
      col_q      <= '0;
      sub_q      <= '0;
      gap_q      <= 1'b0;
      gap_cnt_q  <= '0;
      row_q      <= '0;
      sel_q      <= 4'hF;
      on_box_q   <= 1'b0;
      rgb_q      <= BG;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      hs2_q      <= 1'b1;
      vs2_q      <= 1'b1;
    end else if (pix_en_i) begin
      if (frame_start_s) begin
        display_q <= pending_q;
      end
      h_active_q <= h_active_d;
      dig_q      <= dig_d;
      col_q      <= col_d;
      sub_q      <= sub_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      row_q      <= row_d;
      sel_q      <= sel_d;
      on_box_q   <= on_box_d;
      rgb_q      <= rgb_d;
      hs1_q      <= hsync_i;
      vs1_q      <= vsync_i;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
    end
  end

  assign sel_o   = sel_q;
  assign rgb_o   = rgb_q;
  assign hsync_o = hs2_q;
  assign vsync_o = vs2_q;

endmodule

// File: tb/tb_digit_renderer.sv
// Directed bench for digit_renderer: table of single-pixel checks plus reset, double-buffer
// and quarter-rate enable sequences. The ROM model sets glyph pixel (r,c) when c==sel or c==r+1.
module tb_digit_renderer;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [11:0] LZ_EXP = BG;
`else
  localparam logic [11:0] LZ_EXP = FG;
`endif

  typedef struct {
    logic [15:0] val;
    logic [9:0]  y;
    logic        von;
    logic [9:0]  x;
    logic [11:0] exp_rgb;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n, pix_en, video_on, hsync_in, vsync_in, digits_valid;
  logic [9:0]        pix_x, pix_y;
  logic [15:0]       digits;
  logic [3:0]        sel;
  logic [19:0][19:0] bitmap;
  logic [11:0]       rgb;
  logic              hsync, vsync;

  int n_cmp = 0;
  int n_fail = 0;
  int rst_assert_x = 2000;
  int rst_release_x = 2000;
  logic [11:0] line_rgb [1024];
  logic [3:0]  line_sel [1024];
  vec_t tbl [$];

  digit_renderer dut (
    .clk_i(clk), .rst_ni(rst_n), .pix_en_i(pix_en), .pix_x_i(pix_x), .pix_y_i(pix_y),
    .video_on_i(video_on), .hsync_i(hsync_in), .vsync_i(vsync_in), .digits_i(digits),
    .digits_valid_i(digits_valid), .sel_o(sel), .bitmap_i(bitmap), .rgb_o(rgb),
    .hsync_o(hsync), .vsync_o(vsync)
  );

  always #5 clk = ~clk;

  // Combinational glyph ROM.
  always_comb begin
    bitmap = '0;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 20; c++)
        bitmap[r][c] = (c == int'(sel)) || (c == r + 1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] v, input int y, input logic von, input int x,
                     input logic [11:0] e);
    vec_t t;
    t.val = v; t.y = 10'(y); t.von = von; t.x = 10'(x); t.exp_rgb = e;
    tbl.push_back(t);
  endtask

  task automatic load_digits(input logic [15:0] v);
    pix_en = 1'b0; digits = v; digits_valid = 1'b1;
    @(posedge clk); #1;
    digits_valid = 1'b0;
  endtask

  task automatic frame_start(input logic ld, input logic [15:0] v);
    pix_en = 1'b1; pix_x = 10'd0; pix_y = 10'd0; digits = v; digits_valid = ld;
    @(posedge clk); #1;
    digits_valid = 1'b0;
  endtask

  // One scan line at full rate; line_rgb[x] holds the colour produced for pixel x.
  task automatic run_line(input int y, input int x0, input int x1, input logic von);
    int prev;
    for (int i = 0; i < 1024; i++) begin
      line_rgb[i] = 12'h5A5;
      line_sel[i] = 4'h0;
    end
    prev = -1;
    for (int x = x0; x <= x1; x++) begin
      if (x == rst_assert_x) rst_n = 1'b0;
      if (x == rst_release_x) rst_n = 1'b1;
      pix_en = 1'b1; pix_x = 10'(x); pix_y = 10'(y); video_on = von;
      hsync_in = pix_x[0]; vsync_in = pix_x[1];
      @(posedge clk); #1;
      if (prev >= 0) line_rgb[prev] = rgb;
      line_sel[x] = sel;
      if (!rst_n && (x % 10 == 0)) begin
        check($sformatf("rst_rgb_x%0d", x), 32'(rgb), 32'(BG));
        check($sformatf("rst_hsync_x%0d", x), 32'(hsync), 32'd1);
        check($sformatf("rst_vsync_x%0d", x), 32'(vsync), 32'd1);
        check($sformatf("rst_sel_x%0d", x), 32'(sel), 32'hF);
      end
      prev = x;
    end
  endtask

  function automatic logic hs_of(input int x);
    logic [9:0] v;
    v = 10'(x);
    return v[0] ^ v[1];
  endfunction

  function automatic logic vs_of(input int x);
    logic [9:0] v;
    v = 10'(x);
    return v[2];
  endfunction

  function automatic logic q_fg(input int x);
    return (x == 202) || (x == 203) || (x == 210) || (x == 211);
  endfunction

  initial begin
    logic [15:0] cur_val;
    logic [9:0]  cur_y;
    logic        cur_von, have_line;
    logic [11:0] e_rgb;
    logic        e_hs, e_vs;

    // Row 0 of 1234 at y=200, rows 19/20 at y=239/240, row 1 at y=202.
    add(16'h1234, 200, 1'b1, 200, BG);  add(16'h1234, 200, 1'b1, 201, BG);
    add(16'h1234, 200, 1'b1, 202, FG);  add(16'h1234, 200, 1'b1, 203, FG);
    add(16'h1234, 200, 1'b1, 204, BG);  add(16'h1234, 200, 1'b1, 240, BG);
    add(16'h1234, 200, 1'b1, 243, BG);  add(16'h1234, 200, 1'b1, 244, BG);
    add(16'h1234, 200, 1'b1, 246, FG);  add(16'h1234, 200, 1'b1, 249, FG);
    add(16'h1234, 200, 1'b1, 250, BG);  add(16'h1234, 200, 1'b1, 290, FG);
    add(16'h1234, 200, 1'b1, 292, BG);  add(16'h1234, 200, 1'b1, 294, FG);
    add(16'h1234, 200, 1'b1, 334, FG);  add(16'h1234, 200, 1'b1, 336, BG);
    add(16'h1234, 200, 1'b1, 340, FG);  add(16'h1234, 200, 1'b1, 371, BG);
    add(16'h1234, 200, 1'b1, 372, BG);
    add(16'h1234, 239, 1'b1, 202, FG);  add(16'h1234, 239, 1'b1, 204, BG);
    add(16'h1234, 239, 1'b1, 242, BG);  add(16'h1234, 239, 1'b1, 334, BG);
    add(16'h1234, 239, 1'b1, 340, FG);
    add(16'h1234, 240, 1'b1, 202, BG);  add(16'h1234, 240, 1'b1, 340, BG);
    add(16'h1234, 199, 1'b1, 202, BG);
    add(16'h1234, 202, 1'b1, 202, FG);  add(16'h1234, 202, 1'b1, 204, FG);
    add(16'h1234, 202, 1'b1, 206, BG);  add(16'h1234, 202, 1'b1, 241, BG);
    add(16'h1234, 200, 1'b0, 202, BG);
    add(16'h0007, 200, 1'b1, 200, LZ_EXP); add(16'h0007, 200, 1'b1, 202, LZ_EXP);
    add(16'h0007, 200, 1'b1, 244, LZ_EXP); add(16'h0007, 200, 1'b1, 288, LZ_EXP);
    add(16'h0007, 200, 1'b1, 332, BG);     add(16'h0007, 200, 1'b1, 334, FG);
    add(16'h0007, 200, 1'b1, 346, FG);
    add(16'h0000, 200, 1'b1, 200, LZ_EXP); add(16'h0000, 200, 1'b1, 288, LZ_EXP);
    add(16'h0000, 200, 1'b1, 332, FG);     add(16'h0000, 200, 1'b1, 334, FG);

    rst_n = 1'b0; pix_en = 1'b1; pix_x = 10'd50; pix_y = 10'd50; video_on = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0; digits = 16'h0000; digits_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", 32'(rgb), 32'(BG));
    check("reset_sel", 32'(sel), 32'hF);
    check("reset_hsync", 32'(hsync), 32'd1);
    check("reset_vsync", 32'(vsync), 32'd1);
    rst_n = 1'b1;

    load_digits(16'h1234);
    frame_start(1'b0, 16'h0000);
    run_line(200, 190, 380, 1'b1);
    check("sel_d0_x200", 32'(line_sel[200]), 32'h1);
    check("sel_d1_x244", 32'(line_sel[244]), 32'h2);
    check("sel_d2_x288", 32'(line_sel[288]), 32'h3);
    check("sel_d3_x332", 32'(line_sel[332]), 32'h4);

    cur_val = 16'h1234; cur_y = 10'd0; cur_von = 1'b0; have_line = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].val != cur_val) begin
        load_digits(tbl[i].val);
        frame_start(1'b0, 16'h0000);
        cur_val = tbl[i].val;
        have_line = 1'b0;
      end
      if (!have_line || tbl[i].y != cur_y || tbl[i].von != cur_von) begin
        run_line(int'(tbl[i].y), 190, 380, tbl[i].von);
        cur_y = tbl[i].y; cur_von = tbl[i].von; have_line = 1'b1;
      end
      check($sformatf("tbl%0d_v%h_y%0d_x%0d", i, tbl[i].val, tbl[i].y, tbl[i].x),
            32'(line_rgb[tbl[i].x]), 32'(tbl[i].exp_rgb));
    end

    // Reset asserted inside the box on one line, released at x=150 on the next.
    rst_assert_x = 220;
    run_line(200, 196, 300, 1'b1);
    rst_assert_x = 2000;
    rst_release_x = 150;
    run_line(201, 100, 380, 1'b1);
    rst_release_x = 2000;
    check("rstdef_x200", 32'(line_rgb[200]), 32'(BG));
    check("rstdef_x201", 32'(line_rgb[201]), 32'(BG));
    check("rstdef_x202", 32'(line_rgb[202]), 32'(FG));
    check("rstdef_x204", 32'(line_rgb[204]), 32'(BG));
    check("rstdef_x230", 32'(line_rgb[230]), 32'(FG));
    check("rstdef_x274", 32'(line_rgb[274]), 32'(FG));
    check("rstdef_x318", 32'(line_rgb[318]), 32'(FG));
    check("rstdef_x362", 32'(line_rgb[362]), 32'(FG));

    // Update on the frame-start cycle shows one frame later.
    load_digits(16'h1234);
    frame_start(1'b0, 16'h0000);
    frame_start(1'b1, 16'h5678);
    run_line(200, 190, 380, 1'b1);
    check("same_cyc_old_x210", 32'(line_rgb[210]), 32'(BG));
    check("same_cyc_old_x340", 32'(line_rgb[340]), 32'(FG));
    frame_start(1'b0, 16'h0000);
    run_line(200, 190, 380, 1'b1);
    check("next_frame_x210", 32'(line_rgb[210]), 32'(FG));
    check("next_frame_x340", 32'(line_rgb[340]), 32'(BG));
    check("next_frame_x348", 32'(line_rgb[348]), 32'(FG));

    // Quarter-rate enable with off-enable garbage on the syncs.
    e_rgb = BG; e_hs = 1'b0; e_vs = 1'b0;
    for (int x = 196; x <= 215; x++) begin
      for (int ph = 0; ph < 4; ph++) begin
        pix_en = (ph == 0); pix_x = 10'(x); pix_y = 10'd200; video_on = 1'b1;
        hsync_in = (ph == 0) ? hs_of(x) : ~hs_of(x);
        vsync_in = (ph == 0) ? vs_of(x) : ~vs_of(x);
        @(posedge clk); #1;
        if (ph == 0) begin
          e_hs = hs_of(x - 1);
          e_vs = vs_of(x - 1);
          e_rgb = q_fg(x - 1) ? FG : BG;
        end
        if (x > 196) begin
          check($sformatf("qr_hsync_x%0d_p%0d", x, ph), 32'(hsync), 32'(e_hs));
          check($sformatf("qr_vsync_x%0d_p%0d", x, ph), 32'(vsync), 32'(e_vs));
          check($sformatf("qr_rgb_x%0d_p%0d", x, ph), 32'(rgb), 32'(e_rgb));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
